path_delay_probe: RTL and testbench

PATH_DELAY_PROBE -- requirements
Module: path_delay_probe

---
 rtl/path_delay_probe.sv | 123 ++++++++++++
 tb/tb_path_delay_probe.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/path_delay_probe.sv
// path_delay_probe: launches a toggle into a gate path and measures the synchronized return latency.
module path_delay_probe #(
  parameter int CNT_W    = 8,
  parameter int TIMEOUT  = 200,
  parameter bit PATH_INV = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic [CNT_W-1:0] threshold,
  output logic             launch,
  input  logic             capture,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] latency,
  output logic [CNT_W-1:0] lat_max,
  output logic             alarm,
  output logic [15:0]      meas_cnt
);
  typedef enum logic [1:0] {IDLE, SETTLE, WAIT, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LIM  = CNT_W'(TIMEOUT);
  state_t           state_q, state_d;
  logic             s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, latency_q, latency_d, lat_max_q, lat_max_d;
  logic             launch_q, launch_d, busy_q, busy_d, done_q, done_d;
  logic             timeout_q, timeout_d, alarm_q, alarm_d;
  logic [15:0]      meas_cnt_q, meas_cnt_d;
  logic             match;
  assign match = s2_q == (launch_q ^ PATH_INV);
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    launch_d   = launch_q;
    latency_d  = latency_q;
    timeout_d  = timeout_q;
    lat_max_d  = lat_max_q;
    alarm_d    = alarm_q;
    meas_cnt_d = meas_cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = start ? SETTLE : IDLE;
      end
      SETTLE: begin
        if (match) begin
          launch_d = ~launch_q;
          cnt_d    = '0;
          state_d  = WAIT;
        end else if (cnt_q == LAST) begin
          state_d   = DONE;
          latency_d = LIM;
          timeout_d = 1'b1;
        end
      end
      WAIT: begin
        // s2 lags the path by two flops, so a zero-delay path matches with cnt_q == 2
        if (match) begin
          state_d   = DONE;
          latency_d = cnt_q;
          timeout_d = 1'b0;
        end else if (cnt_q == LAST) begin
          state_d   = DONE;
          latency_d = LIM;
          timeout_d = 1'b1;
        end
      end
      DONE: begin
        state_d    = IDLE;
        meas_cnt_d = meas_cnt_q + 16'd1;
        lat_max_d  = (!timeout_q && latency_q > lat_max_q) ? latency_q : lat_max_q;
        alarm_d    = alarm_q | timeout_q | (latency_q > threshold);
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      alarm_d    = 1'b0;
      lat_max_d  = '0;
      meas_cnt_d = '0;
    end
    busy_d = (state_d == SETTLE) || (state_d == WAIT);
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      cnt_q      <= '0;
      launch_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      latency_q  <= '0;
      lat_max_q  <= '0;
      alarm_q    <= 1'b0;
      meas_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      s1_q       <= capture;
      s2_q       <= s1_q;
      cnt_q      <= cnt_d;
      launch_q   <= launch_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      latency_q  <= latency_d;
      lat_max_q  <= lat_max_d;
      alarm_q    <= alarm_d;
      meas_cnt_q <= meas_cnt_d;
    end
  end
  assign launch   = launch_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign latency  = latency_q;
  assign lat_max  = lat_max_q;
  assign alarm    = alarm_q;
  assign meas_cnt = meas_cnt_q;
endmodule

// File: tb/tb_path_delay_probe.sv
// tb_path_delay_probe: directed checks of a non-inverting and an inverting probe against modelled paths.
module tb_path_delay_probe;
  logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [7:0]  threshold = 8'd6;
  logic        launch0, launch1, capture0, capture1;
  logic        busy0, busy1, done0, done1, timeout0, timeout1, alarm0, alarm1;
  logic [7:0]  latency0, latency1, lat_max0, lat_max1;
  logic [15:0] meas_cnt0, meas_cnt1;
  logic [15:0] dly0 = '0;
  logic [3:0]  d0 = 4'd0;
  logic        stuck0 = 1'b0, inv1 = 1'b0;
  int          errors = 0, checks = 0, cyc = 0, dcount = 0;

  always #5 clk = ~clk;

  always @(posedge clk) dly0 <= {dly0[14:0], launch0};
  always_comb capture0 = stuck0 ? 1'b0 : (d0 == 4'd0 ? launch0 : dly0[d0 - 4'd1]);
  always_comb capture1 = inv1 ? ~launch1 : launch1;

  path_delay_probe #(.CNT_W(8), .TIMEOUT(200), .PATH_INV(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .clear(clear), .threshold(threshold),
    .launch(launch0), .capture(capture0), .busy(busy0), .done(done0), .timeout(timeout0),
    .latency(latency0), .lat_max(lat_max0), .alarm(alarm0), .meas_cnt(meas_cnt0));

  path_delay_probe #(.CNT_W(8), .TIMEOUT(200), .PATH_INV(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .clear(1'b0), .threshold(threshold),
    .launch(launch1), .capture(capture1), .busy(busy1), .done(done1), .timeout(timeout1),
    .latency(latency1), .lat_max(lat_max1), .alarm(alarm1), .meas_cnt(meas_cnt1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run(input bit u, output int n);
    @(negedge clk);
    if (u) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    n = 0;
    while (!(u ? done1 : done0) && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", u ? done1 : done0, 1);
  endtask

  initial begin
    #2;
    chk("rst_launch", launch0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_latency", latency0, 0);
    chk("rst_meas_cnt", meas_cnt0, 0);
    @(negedge clk); rst_n = 1'b1;
    // zero-delay path
    run(0, cyc);
    chk("m1_cycles", cyc, 4);
    chk("m1_latency", latency0, 2);
    chk("m1_timeout", timeout0, 0);
    chk("m1_launch", launch0, 1);
    @(posedge clk); #1;
    chk("m1_done_pulse", done0, 0);
    chk("m1_meas_cnt", meas_cnt0, 1);
    chk("m1_alarm", alarm0, 0);
    chk("m1_lat_max", lat_max0, 2);
    // five-cycle path delay, above threshold
    d0 = 4'd5;
    repeat (8) @(posedge clk);
    run(0, cyc);
    chk("m2_cycles", cyc, 9);
    chk("m2_latency", latency0, 7);
    chk("m2_launch", launch0, 0);
    @(posedge clk); #1;
    chk("m2_alarm", alarm0, 1);
    chk("m2_lat_max", lat_max0, 7);
    // capture stuck low after the toggle
    stuck0 = 1'b1;
    repeat (4) @(posedge clk);
    run(0, cyc);
    chk("m3_cycles", cyc, 201);
    chk("m3_latency", latency0, 200);
    chk("m3_timeout", timeout0, 1);
    chk("m3_launch", launch0, 1);
    @(posedge clk); #1;
    chk("m3_lat_max", lat_max0, 7);
    chk("m3_alarm", alarm0, 1);
    // one-cycle delay
    stuck0 = 1'b0;
    d0 = 4'd1;
    repeat (6) @(posedge clk);
    run(0, cyc);
    chk("m4_latency", latency0, 3);
    chk("m4_timeout", timeout0, 0);
    @(posedge clk); #1;
    chk("m4_lat_max", lat_max0, 7);
    chk("m4_meas_cnt", meas_cnt0, 4);
    // start held high, clear during DONE
    d0 = 4'd0;
    repeat (4) @(posedge clk);
    @(negedge clk); start0 = 1'b1;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!done0 && cyc < 600);
    chk("m5_done_seen", done0, 1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_alarm", alarm0, 0);
    chk("clr_lat_max", lat_max0, 0);
    chk("clr_meas_cnt", meas_cnt0, 0);
    chk("clr_idle_busy", busy0, 0);
    @(posedge clk); #1;
    chk("held_restart_busy", busy0, 1);
    start0 = 1'b0;
    cyc = 0;
    while (!done0 && cyc < 600) begin @(posedge clk); #1; cyc++; end
    chk("m6_done_seen", done0, 1);
    chk("m6_latency", latency0, 2);
    @(posedge clk); #1;
    chk("m6_meas_cnt", meas_cnt0, 1);
    chk("m6_lat_max", lat_max0, 2);
    chk("m6_busy", busy0, 0);
    // inverting path: first a non-inverting capture times out in SETTLE
    run(1, cyc);
    chk("inv_to_cycles", cyc, 200);
    chk("inv_to_latency", latency1, 200);
    chk("inv_to_timeout", timeout1, 1);
    chk("inv_to_launch", launch1, 0);
    inv1 = 1'b1;
    repeat (4) @(posedge clk);
    run(1, cyc);
    chk("inv_latency", latency1, 2);
    chk("inv_timeout", timeout1, 0);
    chk("inv_launch", launch1, 1);
    @(posedge clk); #1;
    chk("inv_meas_cnt", meas_cnt1, 2);
    chk("inv_lat_max", lat_max1, 2);
    // asynchronous reset in WAIT
    d0 = 4'd5;
    repeat (8) @(posedge clk);
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_busy", busy0, 1);
    chk("pre_rst_launch", launch0, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_launch", launch0, 0);
    chk("arst_busy", busy0, 0);
    chk("arst_lat_max", lat_max0, 0);
    chk("arst_latency", latency0, 0);
    chk("arst_meas_cnt", meas_cnt0, 0);
    chk("arst_alarm1", alarm1, 0);
    @(negedge clk); rst_n = 1'b1;
    dcount = 0;
    repeat (15) begin @(posedge clk); #1; if (done0) dcount++; end
    chk("arst_no_done", dcount, 0);
    run(0, cyc);
    chk("post_rst_cycles", cyc, 9);
    chk("post_rst_latency", latency0, 7);
    @(posedge clk); #1;
    chk("post_rst_meas_cnt", meas_cnt0, 1);
    chk("post_rst_alarm", alarm0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
